// File: rtl/instruction_encoder.sv
// Encodes operations into 8-bit program-memory words, buffered in a 4-entry FIFO.
// Define NOP_PAD_EN to follow every JUMP/JUMP_NZ with a 0xC8 NOP delay-slot word.
module instruction_encoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_type,
    input  logic [2:0] dst,
    input  logic [2:0] src,
    input  logic [3:0] data,
    input  logic       x_sel,
    input  logic       y_sel,
    input  logic [2:0] func,
    output logic       pm_wr_valid,
    input  logic       pm_wr_ready,
    output logic [7:0] pm_wr_data,
    output logic [7:0] pm_wr_addr,
    output logic [2:0] fifo_level,
    output logic       err
);

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_MOVE    = 3'd1,
        OP_ALU     = 3'd2,
        OP_JUMP    = 3'd3,
        OP_JUMP_NZ = 3'd4
    } op_t;

    localparam logic [7:0] NOP_WORD = 8'hC8;
`ifdef NOP_PAD_EN
    localparam logic [2:0] READY_MAX = 3'd2;
    localparam bit         PAD_EN    = 1'b1;
`else
    localparam logic [2:0] READY_MAX = 3'd3;
    localparam bit         PAD_EN    = 1'b0;
`endif

    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] level;
    logic [2:0] level_next;
    logic [2:0] push_cnt;
    logic       active;
    logic       accept;
    logic       transfer;
    logic       legal;
    logic       is_jump;
    logic [7:0] word;

    always_comb begin
        word    = '0;
        legal   = 1'b1;
        is_jump = 1'b0;
        case (op_type)
            OP_LOAD:    word = {1'b0, dst, data};
            OP_MOVE:    word = {2'b10, dst, src};
            OP_ALU:     word = {3'b110, x_sel, y_sel, func};
            OP_JUMP: begin
                word    = {4'b1110, data};
                is_jump = 1'b1;
            end
            OP_JUMP_NZ: begin
                word    = {4'b1111, data};
                is_jump = 1'b1;
            end
            default:    legal = 1'b0;
        endcase
    end

    // active holds op_ready low through reset and the edge that releases it
    always_comb begin
        op_ready    = active && (level <= READY_MAX);
        accept      = op_valid && op_ready;
        pm_wr_valid = (level != 3'd0);
        transfer    = pm_wr_valid && pm_wr_ready;
        pm_wr_data  = pm_wr_valid ? mem[rd_ptr] : '0;
        fifo_level  = level;
        push_cnt    = 3'd0;
        if (accept && legal) begin
            push_cnt = (PAD_EN && is_jump) ? 3'd2 : 3'd1;
        end
        level_next  = level + push_cnt - {2'b00, transfer};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            active     <= 1'b0;
            err        <= 1'b0;
            pm_wr_addr <= '0;
        end else begin
            active <= 1'b1;
            err    <= accept && !legal;
            level  <= level_next;
            wr_ptr <= wr_ptr + push_cnt[1:0];
            if (transfer) begin
                rd_ptr     <= rd_ptr + 2'd1;
                pm_wr_addr <= pm_wr_addr + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_cnt != 3'd0) begin
            mem[wr_ptr] <= word;
        end
        if (push_cnt == 3'd2) begin
            mem[wr_ptr + 2'd1] <= NOP_WORD;
        end
    end

endmodule
